// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 keypad scanner.
`timescale 1ns/1ps
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Key FSM: no key, exactly one key, or a chord of two or more keys.
    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_MULTI    = 2'd2
    } key_state_e;

    // Key codes are row*NUM_COLS+col.
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

endpackage

// File: rtl/keypad_map_encode.sv
// Combinational key-map encoder: popcount saturating at 2 plus lowest set index.
`timescale 1ns/1ps
module keypad_map_encode
    import keypad_pkg::*;
(
    input  logic [NUM_KEYS-1:0] map,
    output logic [1:0]          count,
    output logic [3:0]          index
);

    // Lowest index wins: scan from the top down so the last hit is the lowest.
    always_comb begin
        count = 2'd0;
        index = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (map[i]) begin
                index = 4'(i);
            end
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (map[i] && (count != 2'd2)) begin
                count = count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row sampling, scan-level debounce and key FSM.
`timescale 1ns/1ps
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int COL_HOLD       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_release,
    output logic                key_held,
    output logic                key_multi,
    output logic [NUM_KEYS-1:0] key_map
);

    localparam int HW = $clog2(COL_HOLD);
    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(COL_HOLD - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic [NUM_KEYS-1:0] prev_snap_q, prev_snap_d;
    logic [SW-1:0]       stable_cnt_q, stable_cnt_d;
    logic [NUM_KEYS-1:0] key_map_q, key_map_d;
    logic                commit_q, commit_d;
    key_state_e          state_q, state_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_release_q, key_release_d;

    logic [NUM_ROWS-1:0] pressed;
    logic [NUM_KEYS-1:0] scan_snap;
    logic                sample;
    logic [1:0]          map_count;
    logic [3:0]          map_index;

    // Rows are asynchronous to clk; idle (released) rows read high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    assign pressed = ~row_sync_q;
    assign sample  = (hold_cnt_q == HOLD_LAST);

    // Exactly one column low; decoded straight from the index so reset is immediate.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign col[gi] = (col_idx_q != 2'(gi));
    end

    // Column timing, snapshot assembly and scan-level debounce.
    always_comb begin
        hold_cnt_d   = hold_cnt_q + 1'b1;
        col_idx_d    = col_idx_q;
        snap_d       = snap_q;
        prev_snap_d  = prev_snap_q;
        stable_cnt_d = stable_cnt_q;
        key_map_d    = key_map_q;
        commit_d     = 1'b0;
        scan_snap    = snap_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            scan_snap[r*NUM_COLS + int'(col_idx_q)] = pressed[r];
        end
        if (sample) begin
            hold_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
            snap_d     = scan_snap;
            if (col_idx_q == 2'(NUM_COLS - 1)) begin
                if (scan_snap == prev_snap_q) begin
                    if (stable_cnt_q != STABLE_MAX) begin
                        stable_cnt_d = stable_cnt_q + 1'b1;
                    end
                end else begin
                    stable_cnt_d = '0;
                end
                prev_snap_d = scan_snap;
                if ((stable_cnt_d == STABLE_MAX) && (scan_snap != key_map_q)) begin
                    key_map_d = scan_snap;
                    commit_d  = 1'b1;
                end
            end
        end
    end

    // Scan and debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q   <= '0;
            col_idx_q    <= '0;
            snap_q       <= '0;
            prev_snap_q  <= '0;
            stable_cnt_q <= '0;
            key_map_q    <= '0;
            commit_q     <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            col_idx_q    <= col_idx_d;
            snap_q       <= snap_d;
            prev_snap_q  <= prev_snap_d;
            stable_cnt_q <= stable_cnt_d;
            key_map_q    <= key_map_d;
            commit_q     <= commit_d;
        end
    end

    keypad_map_encode u_encode (
        .map   (key_map_q),
        .count (map_count),
        .index (map_index)
    );

    // Key FSM next state; only reacts in the cycle after a new map is committed.
    always_comb begin
        state_d       = state_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        if (commit_q) begin
            case (state_q)
                ST_RELEASED: begin
                    if (map_count == 2'd1) begin
                        state_d     = ST_PRESSED;
                        key_code_d  = map_index;
                        key_valid_d = 1'b1;
                    end else if (map_count == 2'd2) begin
                        state_d = ST_MULTI;
                    end
                end
                ST_PRESSED: begin
                    if (map_count == 2'd0) begin
                        state_d       = ST_RELEASED;
                        key_release_d = 1'b1;
                    end else if (map_count == 2'd1) begin
                        if (map_index != key_code_q) begin
                            key_code_d  = map_index;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_MULTI;
                    end
                end
                ST_MULTI: begin
                    if (map_count == 2'd0) begin
                        state_d = ST_RELEASED;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    // Key FSM state and registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RELEASED;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_held    = (state_q == ST_PRESSED);
    assign key_multi   = (state_q == ST_MULTI);
    assign key_map     = key_map_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: physical keypad model plus event-level reference.
`timescale 1ns/1ps
module tb_keypad_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_held;
    logic        key_multi;
    logic [15:0] key_map;

    logic [15:0] keys;

    int checks_total;
    int checks_passed;

    // Reference model: what a user of the keypad expects, in terms of key sets.
    localparam int M_REL   = 0;
    localparam int M_PRESS = 1;
    localparam int M_MULTI = 2;
    int          m_state;
    logic [3:0]  m_code;
    logic [15:0] m_set;

    // Window observation counters.
    int          w_valid, w_release, w_mapchg, w_first, w_cyc;
    logic [15:0] w_last_map;

    // Protocol monitor counters.
    int   viol;
    logic prev_evt;

    keypad_scan #(.COL_HOLD(4), .DEBOUNCE_SCANS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held),
        .key_multi   (key_multi),
        .key_map     (key_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key on it sits on a driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    // Event pulses must never coincide nor occur back to back.
    always @(negedge clk) begin
        if (rst) begin
            prev_evt <= 1'b0;
        end else begin
            if ((key_valid && key_release) || ((key_valid || key_release) && prev_evt)) begin
                viol <= viol + 1;
            end
            prev_evt <= key_valid || key_release;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_window(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w_cyc++;
            if (key_valid) begin
                w_valid++;
                if (w_first == 0) w_first = w_cyc;
            end
            if (key_release) begin
                w_release++;
                if (w_first == 0) w_first = w_cyc;
            end
            if (key_map !== w_last_map) begin
                w_mapchg++;
                w_last_map = key_map;
            end
        end
    endtask

    task automatic clear_window();
        w_valid    = 0;
        w_release  = 0;
        w_mapchg   = 0;
        w_first    = 0;
        w_cyc      = 0;
        w_last_map = key_map;
    endtask

    // Apply the spec's rules to a stable key-set change; returns expected pulse counts.
    task automatic model_step(input logic [15:0] new_set, output int exp_v, output int exp_r);
        int n;
        logic [3:0] idx;
        exp_v = 0;
        exp_r = 0;
        n     = $countones(new_set);
        idx   = 4'd0;
        for (int i = 15; i >= 0; i--) if (new_set[i]) idx = 4'(i);
        if (new_set != m_set) begin
            if (m_state == M_REL) begin
                if (n == 1) begin m_state = M_PRESS; m_code = idx; exp_v = 1; end
                else if (n >= 2) m_state = M_MULTI;
            end else if (m_state == M_PRESS) begin
                if (n == 0) begin m_state = M_REL; exp_r = 1; end
                else if (n == 1) begin
                    if (idx != m_code) begin m_code = idx; exp_v = 1; end
                end else m_state = M_MULTI;
            end else begin
                if (n == 0) m_state = M_REL;
            end
        end
        m_set = new_set;
    endtask

    task automatic check_state(input string tag);
        check({tag, ":map"},   32'(key_map),   32'(m_set));
        check({tag, ":code"},  32'(key_code),  32'(m_code));
        check({tag, ":held"},  32'(key_held),  32'(m_state == M_PRESS));
        check({tag, ":multi"}, 32'(key_multi), 32'(m_state == M_MULTI));
    endtask

    task automatic apply_keys(input logic [15:0] new_set, input string tag);
        int exp_v, exp_r;
        logic changed;
        changed = (new_set != m_set);
        model_step(new_set, exp_v, exp_r);
        clear_window();
        keys = new_set;
        run_window(100);
        check({tag, ":valid"},   32'(w_valid),   32'(exp_v));
        check({tag, ":release"}, 32'(w_release), 32'(exp_r));
        check({tag, ":mapchg"},  32'(w_mapchg),  32'(changed));
        if (exp_v + exp_r > 0) begin
            check({tag, ":latency<=68"}, 32'(w_first > 0 && w_first <= 68), 32'd1);
        end
        check_state(tag);
        $display("txn %-10s keys=%04h code=%0d valid=%0d release=%0d held=%0d multi=%0d",
                 tag, new_set, key_code, w_valid, w_release, key_held, key_multi);
    endtask

    initial begin
        int kind, k1, k2;
        logic [15:0] s;
        checks_total  = 0;
        checks_passed = 0;
        viol          = 0;
        keys          = 16'h0;
        m_state       = M_REL;
        m_code        = 4'd0;
        m_set         = 16'h0;

        // Power-on reset.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst:col",     32'(col),         32'hE);
        check("rst:valid",   32'(key_valid),   32'd0);
        check("rst:release", 32'(key_release), 32'd0);
        check_state("rst");
        rst = 1'b0;

        // Commit a key, then reset mid-scan with it still held.
        apply_keys(16'h0010, "pre_rst");
        repeat ($urandom_range(1, 9)) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst:col",  32'(col),      32'hE);
        check("midrst:map",  32'(key_map),  32'd0);
        check("midrst:code", 32'(key_code), 32'd0);
        check("midrst:held", 32'(key_held), 32'd0);
        keys    = 16'h0;
        m_state = M_REL;
        m_code  = 4'd0;
        m_set   = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s = 16'h0;
            s[i/4] = 1'b1;
            check($sformatf("colseq%0d", i), 32'(col), 32'(~s[3:0] & 4'hF));
            @(negedge clk);
        end
        $display("txn reset     col sequence checked");

        // Clean press of r=1,c=2 and its release.
        apply_keys(16'h0040, "press6");
        apply_keys(16'h0000, "release6");

        // Bounce on r=3,c=3, then settle pressed.
        clear_window();
        for (int p = 0; p < 4; p++) begin
            keys = (p % 2 == 0) ? 16'h8000 : 16'h0000;
            run_window(10);
        end
        check("bounce:nocommit", 32'(w_mapchg), 32'd0);
        keys = 16'h8000;
        run_window(100);
        m_state = M_PRESS;
        m_code  = 4'hF;
        m_set   = 16'h8000;
        check("bounce:valid",   32'(w_valid),   32'd1);
        check("bounce:release", 32'(w_release), 32'd0);
        check("bounce:mapchg",  32'(w_mapchg),  32'd1);
        check_state("bounce");
        $display("txn bounce    code=%0d valid=%0d", key_code, w_valid);
        apply_keys(16'h0000, "rel15");

        // Multi-key chord.
        apply_keys(16'h0001, "hold0");
        apply_keys(16'h0021, "add5");
        apply_keys(16'h0001, "drop5");
        apply_keys(16'h0000, "relall");

        // Roll-over from key 2 straight to key 9.
        apply_keys(16'h0004, "hold2");
        apply_keys(16'h0200, "roll9");
        apply_keys(16'h0000, "rel9");

        // Random stable key-set changes.
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            k1   = $urandom_range(0, 15);
            k2   = (k1 + $urandom_range(1, 15)) % 16;
            s    = 16'h0;
            if (kind == 1) s[k1] = 1'b1;
            else if (kind == 2) begin s[k1] = 1'b1; s[k2] = 1'b1; end
            else if (kind == 3) s = m_set;
            apply_keys(s, $sformatf("rand%0d", t));
        end

        check("protocol", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Scans a 4x4 passive matrix keypad and turns key presses into debounced, encoded key events for the lab-board top level. It is the input-side counterpart of the row-scanned dot-matrix display driver. It drives one column low at a time, reads the active-low rows and builds a 16-bit key map once per scan. The map is debounced across scans, and single-key press/release events are reported with a 4-bit code, for example to feed the display's digit select.

Parameters:
COL_HOLD, 4, clk cycles each column is driven; rows are sampled on the last cycle; minimum 3.
DEBOUNCE_SCANS, 3, consecutive identical full-scan snapshots required before the stable map is updated; minimum 1.

Ports:
clk  in  1  scan clock, 1 kHz board clock.
rst  in  1  reset, asynchronous, active-high.
row  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
col  out  4  column drive, active-low, exactly one bit low at all times.
key_code  out  4  code of the last accepted key, row*4+col.
key_valid  out  1  one-cycle pulse when a new single key is accepted.
key_release  out  1  one-cycle pulse when a held single key is released to no keys.
key_held  out  1  high while exactly one key is held (FSM in PRESSED).
key_multi  out  1  high while the FSM is in MULTI.
key_map  out  16  debounced stable map; bit r*4+c is 1 when that key is pressed.

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_release=0, key_held=0, key_multi=0, key_map=0. All internal counters and maps are 0; FSM is RELEASED.
- Row input path: 2-flop synchronizer on row. Pressed bit is the inverse of the synchronized row.
- Column drive:
  - col_idx 0..3 cycles in order 0,1,2,3,0; col = ~(1<<col_idx).
  - hold_cnt counts 0..COL_HOLD-1. When hold_cnt==COL_HOLD-1, the synchronized rows are written into snapshot bits {r*4+col_idx}, then col_idx advances and wraps 3->0.
- Scan period is 4*COL_HOLD cycles (16 at default). The snapshot is complete on the sample cycle of col_idx 3 (scan_done).
- Debounce, evaluated on scan_done:
  - If the new snapshot equals the previous snapshot, stable_cnt saturates upward; otherwise stable_cnt=0. The previous snapshot is then updated.
  - When stable_cnt reaches DEBOUNCE_SCANS-1 and the snapshot differs from key_map, key_map is updated in the next cycle (commit).
  - With DEBOUNCE_SCANS=1, every scan commits.
- Key FSM, evaluated only in the cycle after a commit; popcount taken on the new key_map:
  - RELEASED:
    - count 1: go to PRESSED, key_code=index, key_valid pulse.
    - count >=2: go to MULTI.
    - count 0: stay.
  - PRESSED:
    - count 0: go to RELEASED, key_release pulse.
    - count 1 with a different index: stay PRESSED, key_code updated, key_valid pulse (roll-over).
    - count >=2: go to MULTI, no pulse.
  - MULTI:
    - count 0: go to RELEASED, no pulse.
    - otherwise stay. No key_valid until a full release.
- key_valid and key_release are mutually exclusive and never asserted on consecutive cycles.
- key_code holds its value after release.
- Boundaries:
  - Bounce shorter than DEBOUNCE_SCANS scans produces no commit.
  - A press landing mid-scan is captured on the next visit to its column.
  - Reset mid-scan returns col to 4'b1110 immediately and discards partial snapshots.
- Press latency from stable row to key_valid is at most (DEBOUNCE_SCANS+1)*4*COL_HOLD + 4 cycles (68 at default).

Decomposition:
- Package keypad_pkg holds: NUM_ROWS=4 and NUM_COLS=4; the key FSM state enum (RELEASED, PRESSED, MULTI); key code constants (KEY_0..KEY_F).
- One sub-module, keypad_map_encode (combinational), turns the 16-bit map into a popcount (saturating at 2) and the lowest set index. It is used by the FSM.

Test Plan:
- Reset: rst pulse mid-scan -> col=4'b1110 next cycle, all outputs 0, col sequence 1110,1101,1011,0111 each held 4 cycles.
- Clean press: key r=1,c=2 held solid -> key_valid single pulse within 68 cycles, key_code=6, key_held=1, key_map=16'h0040.
- Release: release that key -> key_release pulse within 68 cycles, key_held=0, key_map=0, key_code stays 6.
- Bounce: row toggles every 10 cycles for 40 cycles, then settles pressed at r=3,c=3 -> exactly one key_valid, key_code=15, no intermediate commits.
- Multi-key: hold key 0, then add key 5 -> key_multi=1, key_map=16'h0021, no extra key_valid. Release key 5 only -> still MULTI. Release all -> RELEASED with no key_release.
- Roll-over: hold key 2, release it and press key 9 within one scan -> single key_valid with key_code=9, key_held stays 1, no key_release.
